// File: rtl/mac_acc_stage.sv
// Accumulate stage behind the 8x8 multiplier: sums a window of 16-bit products
// into a saturating accumulator and hands the sum and an 8-bit requantised value downstream.
module mac_acc_stage #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    input  logic [3:0]       shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_q,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    // Handshakes: a beat or result moves on a rising edge where valid && ready are both high;
    // in_ready depends only on registers, and a producer must hold a beat until it is taken.
    typedef enum logic {ST_ACC, ST_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [15:0]      r_p_q;
    logic             r_p_last;
    logic             r_p_v;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_sum;
    logic [7:0]       r_out_q;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_ovf;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_accum;
    logic             w_close;
    logic             w_release;
    logic [ACC_W:0]   w_sum_ext;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_sat;
    logic             w_ovf_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [ACC_W-1:0] w_shifted;
    logic [7:0]       w_q;

    assign w_in_ready = (r_state == ST_ACC) && !(r_p_v && r_p_last);
    assign w_accept   = in_valid && w_in_ready;
    assign w_accum    = (r_state == ST_ACC) && r_p_v;
    assign w_close    = w_accum && r_p_last;
    assign w_release  = (r_state == ST_DONE) && out_ready;

    // One extra bit on the adder exposes the carry that triggers saturation.
    assign w_sum_ext  = {1'b0, r_acc} + {{(ACC_W - 15){1'b0}}, r_p_q};
    assign w_carry    = w_sum_ext[ACC_W];
    assign w_acc_sat  = w_carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
    assign w_ovf_nxt  = r_ovf | w_carry;
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_shifted  = w_acc_sat >> shift;
    assign w_q        = (|w_shifted[ACC_W-1:8]) ? 8'hFF : w_shifted[7:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:  if (w_close)   w_state_nxt = ST_DONE;
            ST_DONE: if (w_release) w_state_nxt = ST_ACC;
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_q    <= '0;
            r_p_last <= 1'b0;
            r_p_v    <= 1'b0;
        end else begin
            r_p_v <= w_accept;
            if (w_accept) begin
                r_p_q    <= in_prod;
                r_p_last <= in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accum) begin
            r_acc <= w_acc_sat;
            r_cnt <= w_cnt_inc;
            r_ovf <= w_ovf_nxt;
        end else if (w_release) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end
    end

    // Result registers load only on DONE entry, so they hold through the handshake and after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_q     <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_acc_sat;
            r_out_q     <= w_q;
            r_out_cnt   <= w_cnt_inc;
            r_out_ovf   <= w_ovf_nxt;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_q     = r_out_q;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;

endmodule
